// File: rtl/sine_voice_mixer.sv
// Polyphonic sine source: one shared sine_lut, time-multiplexed across NUM_VOICES
// phase accumulators, summed into a single mixed sample per step strobe.
module sine_voice_mixer #(
  parameter int NUM_VOICES = 4,
  parameter int OUT_W      = 8 + $clog2(NUM_VOICES)
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic                       step_in,
  input  logic                       cfg_we_in,
  input  logic [$clog2(NUM_VOICES)-1:0] cfg_voice_in,
  input  logic [31:0]                cfg_incr_in,
  input  logic                       cfg_en_in,
  output logic signed [OUT_W-1:0]    sample_out,
  output logic                       sample_valid_out,
  output logic                       busy_out,
  output logic                       overrun_out
);

  localparam int IDX_W = $clog2(NUM_VOICES);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_VOICES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                  state, state_nxt;
  logic [IDX_W-1:0]        idx;
  logic [31:0]             phase [NUM_VOICES];
  logic [31:0]             incr  [NUM_VOICES];
  logic [NUM_VOICES-1:0]   en;
  logic [NUM_VOICES-1:0]   wr_hit;
  logic                    start;
  logic [31:0]             cur_phase;
  logic [7:0]              lut_p1;
  logic                    vld_p1, en_p1;
  logic signed [OUT_W-1:0] term_p1, acc_p2, sample_r;
  logic                    valid_r;

  function automatic logic signed [OUT_W-1:0] to_amp(input logic [7:0] code);
    logic signed [7:0] a;
    a = {~code[7], code[6:0]};
    return {{(OUT_W-8){a[7]}}, a};
  endfunction

  assign start     = (state == IDLE) && step_in;
  assign cur_phase = phase[idx];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (step_in) state_nxt = ISSUE;
      ISSUE:   if (idx == LAST) state_nxt = DRAIN;
      DRAIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      if (start)
        idx <= '0;
      else if (state == ISSUE)
        idx <= idx + 1'b1;
    end
  end

  always_comb begin
    wr_hit = '0;
    for (int v = 0; v < NUM_VOICES; v++)
      wr_hit[v] = cfg_we_in && (cfg_voice_in == IDX_W'(v));
  end

  // A disabling write wins over the ISSUE advance; the LUT still reads the old phase.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      en <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        phase[v] <= '0;
        incr[v]  <= '0;
      end
    end else begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (wr_hit[v]) begin
          incr[v] <= cfg_incr_in;
          en[v]   <= cfg_en_in;
        end
        if (wr_hit[v] && !cfg_en_in)
          phase[v] <= '0;
        else if ((state == ISSUE) && (idx == IDX_W'(v)) && en[v])
          phase[v] <= phase[v] + incr[v];
      end
    end
  end

  // Stage p0 -> p1: LUT read of the issued voice; its enable travels alongside.
  sine_lut u_lut (
    .clk  (clk_in),
    .addr (cur_phase[31:26]),
    .data (lut_p1)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      vld_p1 <= 1'b0;
      en_p1  <= 1'b0;
    end else begin
      vld_p1 <= (state == ISSUE);
      en_p1  <= en[idx];
    end
  end

  assign term_p1 = (vld_p1 && en_p1) ? to_amp(lut_p1) : '0;

  // Stage p1 -> p2: running sum; worst case NUM_VOICES*128 fits OUT_W.
  always_ff @(posedge clk_in) begin
    if (start)
      acc_p2 <= '0;
    else if (vld_p1)
      acc_p2 <= acc_p2 + term_p1;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sample_r <= '0;
      valid_r  <= 1'b0;
    end else begin
      valid_r <= (state == DRAIN);
      if (state == DRAIN)
        sample_r <= acc_p2 + term_p1;
    end
  end

  assign sample_out       = sample_r;
  assign sample_valid_out = valid_r;
  assign busy_out         = (state != IDLE);
  assign overrun_out      = step_in && (state != IDLE);

endmodule

// 64-entry registered sine table, offset-binary: code = 128 + floor(128*sin), capped at 255.
module sine_lut (
  input  logic       clk,
  input  logic [5:0] addr,
  output logic [7:0] data
);

  function automatic logic [7:0] pos_mag(input logic [4:0] q);
    case (q)
      5'd0:  return 8'd0;    5'd1:  return 8'd12;   5'd2:  return 8'd24;
      5'd3:  return 8'd37;   5'd4:  return 8'd48;   5'd5:  return 8'd60;
      5'd6:  return 8'd71;   5'd7:  return 8'd81;   5'd8:  return 8'd90;
      5'd9:  return 8'd98;   5'd10: return 8'd106;  5'd11: return 8'd112;
      5'd12: return 8'd118;  5'd13: return 8'd122;  5'd14: return 8'd125;
      5'd15: return 8'd127;  5'd16: return 8'd127;
      default: return 8'd0;
    endcase
  endfunction

  function automatic logic [7:0] neg_mag(input logic [4:0] q);
    case (q)
      5'd0:  return 8'd0;    5'd1:  return 8'd13;   5'd2:  return 8'd25;
      5'd3:  return 8'd38;   5'd4:  return 8'd49;   5'd5:  return 8'd61;
      5'd6:  return 8'd72;   5'd7:  return 8'd82;   5'd8:  return 8'd91;
      5'd9:  return 8'd99;   5'd10: return 8'd107;  5'd11: return 8'd113;
      5'd12: return 8'd119;  5'd13: return 8'd123;  5'd14: return 8'd126;
      5'd15: return 8'd128;  5'd16: return 8'd128;
      default: return 8'd0;
    endcase
  endfunction

  function automatic logic [7:0] code_of(input logic [5:0] a);
    logic [4:0] q;
    q = a[4:0];
    if (q > 5'd16)
      q = 5'(6'd32 - {1'b0, a[4:0]});
    if (!a[5])
      return 8'd128 + pos_mag(q);
    return 8'd128 - neg_mag(q);
  endfunction

  always_ff @(posedge clk)
    data <= code_of(addr);

endmodule

// File: tb/tb_sine_voice_mixer.sv
// Scoreboard bench for sine_voice_mixer: driver feeds a sample-level reference model,
// a monitor pops expected mixes on every valid pulse.
module tb_sine_voice_mixer;

  localparam int NV = 4;
  localparam int OW = 10;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 step_in, cfg_we_in, cfg_en_in;
  logic [1:0]           cfg_voice_in;
  logic [31:0]          cfg_incr_in;
  logic signed [OW-1:0] sample_out;
  logic                 sample_valid_out, busy_out, overrun_out;

  sine_voice_mixer #(.NUM_VOICES(NV)) dut (
    .clk_in           (clk),
    .rst_n_in         (rst_n),
    .step_in          (step_in),
    .cfg_we_in        (cfg_we_in),
    .cfg_voice_in     (cfg_voice_in),
    .cfg_incr_in      (cfg_incr_in),
    .cfg_en_in        (cfg_en_in),
    .sample_out       (sample_out),
    .sample_valid_out (sample_valid_out),
    .busy_out         (busy_out),
    .overrun_out      (overrun_out)
  );

  always #5 clk = ~clk;

  typedef struct { int val; int cyc; } exp_t;
  exp_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_valid = 0;
  int last_sample = 0;

  logic [31:0] m_phase [NV];
  logic [31:0] m_incr  [NV];
  bit          m_en    [NV];
  bit          m_active = 0;
  int          m_start  = 0;
  int          m_acc    = 0;
  bit          exp_busy = 0;
  bit          exp_overrun = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Amplitude of the table entry addressed by the top six phase bits.
  function automatic int amp_of(input logic [31:0] ph);
    real a;
    int  r;
    a = 128.0 * $sin(2.0 * 3.141592653589793 * real'(int'(ph[31:26])) / 64.0) + 1.0e-9;
    r = int'($floor(a));
    if (r > 127) r = 127;
    return r;
  endfunction

  function automatic void model_reset();
    for (int v = 0; v < NV; v++) begin
      m_phase[v] = '0; m_incr[v] = '0; m_en[v] = 0;
    end
    m_active = 0; m_acc = 0; exp_busy = 0; exp_overrun = 0;
    sb.delete();
  endfunction

  // One clock cycle of stimulus; entered and left 1 time unit after a rising edge.
  task automatic tick(input bit step, input bit we, input int v,
                      input logic [31:0] inc, input bit en);
    int t, d, vv;
    t = cyc;
    step_in = step; cfg_we_in = we; cfg_voice_in = 2'(v);
    cfg_incr_in = inc; cfg_en_in = en;
    exp_busy = m_active;
    exp_overrun = 0;
    if (m_active) begin
      d = t - m_start;
      if (d >= 1 && d <= NV) begin
        vv = d - 1;
        if (m_en[vv]) begin
          m_acc += amp_of(m_phase[vv]);
          m_phase[vv] = m_phase[vv] + m_incr[vv];
        end
      end
      if (d == NV + 1) begin
        sb.push_back('{m_acc, t + 1});
        m_active = 0;
      end
    end
    if (we) begin
      m_incr[v] = inc;
      m_en[v]   = en;
      if (!en) m_phase[v] = '0;
    end
    if (step) begin
      if (exp_busy) exp_overrun = 1;
      else begin m_active = 1; m_start = t; m_acc = 0; end
    end
    @(posedge clk); #1;
    step_in = 0; cfg_we_in = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 32'h0, 0);
  endtask

  task automatic cfg(input int v, input logic [31:0] inc, input bit en);
    tick(0, 1, v, inc, en);
  endtask

  task automatic run_step(input string name, input int exp);
    tick(1, 0, 0, 32'h0, 0);
    idle(7);
    check(name, last_sample, exp);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_sample"},  int'(sample_out), 0);
    check({tag, "_valid"},   int'(sample_valid_out), 0);
    check({tag, "_busy"},    int'(busy_out), 0);
    check({tag, "_overrun"}, int'(overrun_out), 0);
  endtask

  // Monitor: flag/handshake checks every cycle, scoreboard pop on each valid.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("busy", int'(busy_out), int'(exp_busy));
        check("overrun", int'(overrun_out), int'(exp_overrun));
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
          e = sb.pop_front();
          check("missing_valid_at_cycle", 0, e.cyc);
        end
        if (sample_valid_out) begin
          n_valid++;
          last_sample = int'(sample_out);
          if (sb.size() == 0) check("unexpected_valid", 1, 0);
          else begin
            e = sb.pop_front();
            check("sample", int'(sample_out), e.val);
            check("valid_cycle", cyc, e.cyc);
          end
        end
      end
    end
  end

  initial begin
    int nv0, t0;
    rst_n = 0; step_in = 0; cfg_we_in = 0; cfg_voice_in = '0;
    cfg_incr_in = '0; cfg_en_in = 0;
    model_reset();
    #3;
    check_outputs_zero("reset");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;

    // Single voice, one LUT step per sample
    cfg(0, 32'h0400_0000, 1);
    run_step("single0", 0);
    run_step("single1", 12);
    run_step("single2", 24);
    run_step("single3", 37);

    // Full mix, quarter-cycle steps on all voices
    cfg(0, 32'h0, 0);
    for (int v = 0; v < NV; v++) cfg(v, 32'h4000_0000, 1);
    run_step("mix0", 0);
    run_step("mix1", 508);
    run_step("mix2", 0);
    run_step("mix3", -512);
    run_step("mix4", 0);

    // Enable subset: voice 2 only, then a disable/re-enable clears its phase
    for (int v = 0; v < NV; v++) cfg(v, 32'h0, 0);
    cfg(2, 32'h4000_0000, 1);
    run_step("sub0", 0);
    run_step("sub1", 127);
    run_step("sub2", 0);
    run_step("sub3", -128);
    cfg(2, 32'h4000_0000, 0);
    cfg(2, 32'h4000_0000, 1);
    run_step("sub_reenable", 0);

    // Overrun: strobes at relative cycles 0, 3, 6
    nv0 = n_valid;
    tick(1, 0, 0, 32'h0, 0);
    idle(2);
    tick(1, 0, 0, 32'h0, 0);
    idle(2);
    tick(1, 0, 0, 32'h0, 0);
    check("overrun_one_valid", n_valid - nv0, 1);
    idle(7);
    check("overrun_second_valid", n_valid - nv0, 2);

    // Config collision on voice 1 during its ISSUE cycle
    for (int v = 0; v < NV; v++) cfg(v, 32'h0, 0);
    cfg(1, 32'h0400_0000, 1);
    run_step("coll_pre0", 0);
    run_step("coll_pre1", 12);
    tick(1, 0, 0, 32'h0, 0);
    idle(1);
    cfg(1, 32'h4000_0000, 1);
    idle(5);
    check("coll_old_phase", last_sample, 24);
    run_step("coll_old_incr", 37);
    run_step("coll_new_incr", 122);
    run_step("coll_new_incr2", -38);

    // Reset in the middle of ISSUE aborts the sample
    cfg(3, 32'h1234_5678, 1);
    nv0 = n_valid;
    tick(1, 0, 0, 32'h0, 0);
    tick(0, 0, 0, 32'h0, 0);
    rst_n = 0;
    model_reset();
    #1;
    check_outputs_zero("midreset");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;
    idle(4);
    check("midreset_no_valid", n_valid - nv0, 0);
    run_step("after_reset", 0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      bit st, we, en;
      int v;
      logic [31:0] inc;
      st = ($urandom_range(0, 3) == 0);
      we = ($urandom_range(0, 5) == 0);
      v  = $urandom_range(0, NV - 1);
      en = ($urandom_range(0, 4) != 0);
      inc = ($urandom_range(0, 1) == 0) ? {$urandom_range(0, 63) , 26'h0} : $urandom;
      tick(st, we, v, inc, en);
    end
    t0 = 0;
    while (sb.size() > 0 && t0 < 20) begin
      idle(1);
      t0++;
    end
    idle(2);
    check("scoreboard_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sine_voice_mixer.md
# sine_voice_mixer

Polyphonic tone source that time-multiplexes one `sine_lut` instance across `NUM_VOICES` independent phase accumulators. On each sample strobe it reads every enabled voice's phase through the LUT and sums the signed amplitudes into one mixed sample. It sits between the sample-rate strobe generator and the audio output path. Per-voice frequency and enable are written at runtime over a simple config port.

## Interface
- `NUM_VOICES`, default 4: voice count, power of two, 2..8.
- `OUT_W`, default `8+$clog2(NUM_VOICES)`: mixed sample width. Do not override.
- `clk_in` input 1: single clock.
- `rst_n_in` input 1: reset, asynchronous and active-low.
- `step_in` input 1: sample strobe, one cycle wide.
- `cfg_we_in` input 1: config write strobe.
- `cfg_voice_in` input `$clog2(NUM_VOICES)`: target voice.
- `cfg_incr_in` input 32: phase increment for the target voice.
- `cfg_en_in` input 1: enable for the target voice.
- `sample_out` output signed `OUT_W`: mixed sample. Held between updates.
- `sample_valid_out` output 1: one-cycle pulse when `sample_out` updates.
- `busy_out` output 1: high while a sample is being computed.
- `overrun_out` output 1: one-cycle pulse when a `step_in` is dropped.

## Operation
- Per-voice state:
  - `phase[v]`, 32 bits.
  - `incr[v]`, 32 bits.
  - `en[v]`, 1 bit.
- LUT:
  - The existing `sine_lut` is instantiated once.
  - Its address is `phase[idx][31:26]`.
  - Its output is registered and offset-binary.
- Amplitude conversion: `amp = {~lut[7], lut[6:0]}` (signed 8-bit), sign-extended to `OUT_W`.
  - A voice with `en=0` contributes 0.
- FSM states: IDLE, ISSUE, DRAIN.
  - IDLE + `step_in` → ISSUE, `idx=0`, accumulator cleared.
  - ISSUE: present voice `idx` to the LUT. If `en[idx]`, `phase[idx] <= phase[idx] + incr[idx]` (mod 2^32). Then `idx++`.
    - Leave for DRAIN after `idx = NUM_VOICES-1`.
  - Accumulate: on every cycle after an ISSUE cycle, add the amplitude of the voice issued on the previous cycle.
  - DRAIN: the final accumulate. Then load `sample_out`, pulse `sample_valid_out`, return to IDLE.
- The sum never overflows: `NUM_VOICES * 128` fits in `OUT_W`. No saturation logic.
- `step_in` while state ≠ IDLE: the strobe is dropped, `overrun_out` pulses in that cycle, and the in-flight sample is unaffected.
- Config writes are accepted in any state, with effect on the next edge:
  - `incr[v] <= cfg_incr_in`
  - `en[v] <= cfg_en_in`
  - If `cfg_en_in = 0`, then also `phase[v] <= 0`.
- Collision (write to voice v in the same cycle v is issued):
  - The LUT reads the old phase, and the old `en` decides the contribution.
  - Phase result: if the write disables v, phase is cleared. Otherwise phase = old phase + old incr. The new incr applies from the next sample.

## Timing
- Reset (async assert) values:
  - All of `phase`, `incr`, `en`, `idx`: 0.
  - `sample_out = 0`.
  - `sample_valid_out = 0`, `busy_out = 0`, `overrun_out = 0`.
  - FSM in IDLE.
- Reset mid-sample aborts it. No valid pulse is produced.
- Cycle numbering, with `step_in` sampled in IDLE at cycle 0:
  - Cycles 1..N: ISSUE of voices 0..N-1.
  - Cycle N+1: DRAIN.
  - Cycle N+2: `sample_valid_out` = 1 and `sample_out` is valid.
  - Latency is N+2 cycles (6 for the default).
- `busy_out` is high in cycles 1..N+1.
- A `step_in` in cycle N+2 is accepted. Maximum sample rate is one per N+2 cycles.
- Phase advance is visible the cycle after the voice's ISSUE cycle.

## Test plan
- Reset:
  - Stimulus: assert `rst_n_in` low mid-ISSUE.
  - Required: all outputs 0 immediately; no `sample_valid_out`; after release, `step_in` gives `sample_out = 0` because all voices are disabled.
- Single voice:
  - Stimulus: voice 0 `en=1`, `incr = 32'h0400_0000` (1 LUT step); four `step_in` strobes spaced 8 cycles apart.
  - Required: `sample_out` = 0, 12, 24, 37; each valid pulse lands exactly 6 cycles after its `step_in`.
- Full mix:
  - Stimulus: all 4 voices `en=1`, `incr = 32'h4000_0000` (16 LUT steps).
  - Required: samples 0, 508, 0, -512, then 0 again (wrap-around).
- Enable subset:
  - Stimulus: only voice 2 enabled, `incr = 32'h4000_0000`.
  - Required: samples 0, 127, 0, -128.
  - Then disable voice 2 and re-enable it. Required: the next sample is 0, because the phase was cleared.
- Overrun:
  - Stimulus: `step_in` at cycles 0 and 3.
  - Required: `overrun_out` high at cycle 3 only; exactly one `sample_valid_out`, at cycle 6.
  - Stimulus: `step_in` at cycle 6. Required: it is accepted, with valid at cycle 12.
- Config collision:
  - Stimulus: write voice 1 `incr = 32'h4000_0000` during voice 1's ISSUE cycle (voice 1 previously running at `32'h0400_0000`).
  - Required: this sample uses the old phase and the old increment; the following sample reflects phase + `32'h0400_0000`; later samples advance 16 LUT steps per sample.
